// File: rtl/multi_box_animator.sv
`default_nettype none
// ============================================================================
//  Module      : multi_box_animator
//  Description : N-object filled-box animator for the 160x120 3-bit VGA adapter.
//                Cycles draw -> hold -> erase -> step. Optional macro BOUNCE_EN
//                makes objects bounce off the screen edges instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module multi_box_animator #(
    parameter int NUM_OBJ         = 4,
    parameter int BOX_W           = 4,
    parameter int BOX_H           = 4,
    parameter int FRAME_DIV       = 833333,
    parameter int FRAMES_PER_STEP = 4,
    parameter int X_MAX           = 159,
    parameter int Y_MAX           = 119
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [8*NUM_OBJ-1:0]   init_x,
    input  logic [7*NUM_OBJ-1:0]   init_y,
    input  logic [2*NUM_OBJ-1:0]   speed,
    input  logic [NUM_OBJ-1:0]     dir,
    input  logic [3*NUM_OBJ-1:0]   colour,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic                   step_done
);

    localparam int c_OBJ_W    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int c_COL_W    = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int c_ROW_W    = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam int c_HOLD_CYC = FRAME_DIV * FRAMES_PER_STEP;

    localparam logic [c_OBJ_W-1:0] c_OBJ_LAST  = c_OBJ_W'(NUM_OBJ - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(BOX_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST  = c_ROW_W'(BOX_H - 1);
    localparam logic [31:0]        c_HOLD_LAST = 32'(c_HOLD_CYC - 1);
    localparam logic [8:0]         c_LIM       = 9'(X_MAX - BOX_W + 1);
    localparam logic [7:0]         c_LIM8      = 8'(X_MAX - BOX_W + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAW   = 3'd1,
        S_HOLD   = 3'd2,
        S_ERASE  = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_OBJ_W-1:0]   r_obj;
    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic [31:0]          r_hold_cnt;

    logic [7:0]           r_pos_x [NUM_OBJ];
    logic [6:0]           r_pos_y [NUM_OBJ];
    logic [2:0]           w_colour [NUM_OBJ];

    logic [8:0]           w_px;
    logic [7:0]           w_py;
    logic                 w_sweep_last;

    // One extra bit so coordinates past the screen edge are detected, not folded.
    assign w_px = {1'b0, r_pos_x[r_obj]} + 9'(r_col);
    assign w_py = {1'b0, r_pos_y[r_obj]} + 8'(r_row);
    assign w_sweep_last = (r_obj == c_OBJ_LAST) && (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        logic [8:0] w_x9;
        logic [8:0] w_sp9;
        logic [8:0] w_sum;
        logic [7:0] w_nx;
        logic       w_dir;

        assign w_colour[i] = colour[3*i +: 3];
        assign w_x9        = {1'b0, r_pos_x[i]};
        assign w_sp9       = {7'd0, speed[2*i +: 2]};
        assign w_sum       = w_x9 + w_sp9;

`ifdef BOUNCE_EN
        logic r_dir;
        logic w_edge;

        assign w_dir = r_dir;

        always_comb begin
            w_nx   = r_pos_x[i];
            w_edge = 1'b0;
            if (w_sp9 != 9'd0) begin
                if (w_dir) begin
                    if (w_sum > c_LIM) begin
                        w_nx   = c_LIM8;
                        w_edge = 1'b1;
                    end else begin
                        w_nx = w_sum[7:0];
                    end
                end else begin
                    if (w_x9 < w_sp9) begin
                        w_nx   = 8'd0;
                        w_edge = 1'b1;
                    end else begin
                        w_nx = r_pos_x[i] - w_sp9[7:0];
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_dir <= dir[i];
            end else if (r_state == S_UPDATE && w_edge) begin
                r_dir <= ~r_dir;
            end
        end
`else
        assign w_dir = dir[i];

        // Results always fit in 8 bits, so the wrap subtractions run modulo 256.
        always_comb begin
            w_nx = r_pos_x[i];
            if (w_sp9 != 9'd0) begin
                if (w_dir) begin
                    if (w_sum > c_LIM) begin
                        w_nx = w_sum[7:0] - c_LIM8 - 8'd1;
                    end else begin
                        w_nx = w_sum[7:0];
                    end
                end else begin
                    if (w_x9 < w_sp9) begin
                        w_nx = c_LIM8 + 8'd1 - (w_sp9[7:0] - r_pos_x[i]);
                    end else begin
                        w_nx = r_pos_x[i] - w_sp9[7:0];
                    end
                end
            end
        end
`endif

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_pos_x[i] <= init_x[8*i +: 8];
                r_pos_y[i] <= init_y[7*i +: 7];
            end else if (r_state == S_UPDATE) begin
                r_pos_x[i] <= w_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_obj      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_hold_cnt <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            step_done  <= 1'b0;
        end else begin
            vga_plot  <= 1'b0;
            step_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_obj <= '0;
                    r_col <= '0;
                    r_row <= '0;
                    if (enable) begin
                        r_state <= S_DRAW;
                        busy    <= 1'b1;
                    end
                end
                S_DRAW, S_ERASE: begin
                    vga_x      <= w_px[7:0];
                    vga_y      <= w_py[6:0];
                    vga_colour <= (r_state == S_DRAW) ? w_colour[r_obj] : 3'b000;
                    vga_plot   <= (w_px <= 9'(X_MAX)) && (w_py <= 8'(Y_MAX));
                    // Counters wrap to zero on the last pixel, ready for the next sweep.
                    if (r_col == c_COL_LAST) begin
                        r_col <= '0;
                        if (r_row == c_ROW_LAST) begin
                            r_row <= '0;
                            r_obj <= (r_obj == c_OBJ_LAST) ? '0 : r_obj + 1'b1;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                    if (w_sweep_last) begin
                        r_state    <= (r_state == S_DRAW) ? S_HOLD : S_UPDATE;
                        r_hold_cnt <= '0;
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state <= S_ERASE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end
                S_UPDATE: begin
                    step_done <= 1'b1;
                    busy      <= enable;
                    r_state   <= enable ? S_DRAW : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_box_animator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multi_box_animator
//  Description : Directed self-checking bench for multi_box_animator (2 objects,
//                2x2 boxes, 8-cycle hold).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multi_box_animator;

    localparam int NUM_OBJ         = 2;
    localparam int BOX_W           = 2;
    localparam int BOX_H           = 2;
    localparam int FRAME_DIV       = 4;
    localparam int FRAMES_PER_STEP = 2;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic [15:0] init_x  = '0;
    logic [13:0] init_y  = '0;
    logic [3:0]  speed   = '0;
    logic [1:0]  dir     = '0;
    logic [5:0]  colour  = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        step_done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic plot;
        int   x;
        int   y;
        int   c;
        logic sd;
    } pix_t;

    typedef struct {
        logic [7:0] x0;
        logic [1:0] sp;
        logic       d;
        int         steps;
        int         exp_x;
    } step_t;

    pix_t  t_pass [25];
    step_t t_step [9];

    always #5 clk = ~clk;

    multi_box_animator #(
        .NUM_OBJ         (NUM_OBJ),
        .BOX_W           (BOX_W),
        .BOX_H           (BOX_H),
        .FRAME_DIV       (FRAME_DIV),
        .FRAMES_PER_STEP (FRAMES_PER_STEP),
        .X_MAX           (159),
        .Y_MAX           (119)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .init_x     (init_x),
        .init_y     (init_y),
        .speed      (speed),
        .dir        (dir),
        .colour     (colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .step_done  (step_done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Object 1 is parked at (10,60), speed 0; object 0 is configurable.
    task automatic start(input logic [7:0] x0, input logic [6:0] y0, input logic [1:0] sp0, input logic d0);
        enable  = 1'b0;
        reset_n = 1'b0;
        init_x  = {8'd10, x0};
        init_y  = {7'd60, y0};
        speed   = {2'd0, sp0};
        dir     = {1'b1, d0};
        colour  = 6'b101_010;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
    endtask

    task automatic wait_plot(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!vga_plot && k < 200);
        check(name, int'(vga_plot), 1);
    endtask

    task automatic wait_step(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!step_done && k < 200);
        check(name, int'(step_done), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Draw: obj0 colour 2, obj1 colour 5; hold gap; erase in black; then step_done.
        t_pass[0]  = '{1'b1, 0, 0, 2, 1'b0};
        t_pass[1]  = '{1'b1, 1, 0, 2, 1'b0};
        t_pass[2]  = '{1'b1, 0, 1, 2, 1'b0};
        t_pass[3]  = '{1'b1, 1, 1, 2, 1'b0};
        t_pass[4]  = '{1'b1, 10, 60, 5, 1'b0};
        t_pass[5]  = '{1'b1, 11, 60, 5, 1'b0};
        t_pass[6]  = '{1'b1, 10, 61, 5, 1'b0};
        t_pass[7]  = '{1'b1, 11, 61, 5, 1'b0};
        for (int i = 8; i < 16; i++) t_pass[i] = '{1'b0, 0, 0, 0, 1'b0};
        t_pass[16] = '{1'b1, 0, 0, 0, 1'b0};
        t_pass[17] = '{1'b1, 1, 0, 0, 1'b0};
        t_pass[18] = '{1'b1, 0, 1, 0, 1'b0};
        t_pass[19] = '{1'b1, 1, 1, 0, 1'b0};
        t_pass[20] = '{1'b1, 10, 60, 0, 1'b0};
        t_pass[21] = '{1'b1, 11, 60, 0, 1'b0};
        t_pass[22] = '{1'b1, 10, 61, 0, 1'b0};
        t_pass[23] = '{1'b1, 11, 61, 0, 1'b0};
        t_pass[24] = '{1'b0, 0, 0, 0, 1'b1};

        // LIM = 159 - 2 + 1 = 158
`ifdef BOUNCE_EN
        t_step[0] = '{8'd0,   2'd2, 1'b1, 1, 2};
        t_step[1] = '{8'd0,   2'd2, 1'b1, 3, 6};
        t_step[2] = '{8'd157, 2'd3, 1'b1, 1, 158};
        t_step[3] = '{8'd1,   2'd3, 1'b0, 1, 0};
        t_step[4] = '{8'd50,  2'd0, 1'b1, 2, 50};
        t_step[5] = '{8'd5,   2'd1, 1'b0, 2, 3};
        t_step[6] = '{8'd157, 2'd3, 1'b1, 2, 155};
        t_step[7] = '{8'd1,   2'd3, 1'b0, 2, 3};
        t_step[8] = '{8'd158, 2'd1, 1'b1, 1, 158};
`else
        t_step[0] = '{8'd0,   2'd2, 1'b1, 1, 2};
        t_step[1] = '{8'd0,   2'd2, 1'b1, 3, 6};
        t_step[2] = '{8'd157, 2'd3, 1'b1, 1, 1};
        t_step[3] = '{8'd1,   2'd3, 1'b0, 1, 157};
        t_step[4] = '{8'd50,  2'd0, 1'b1, 2, 50};
        t_step[5] = '{8'd5,   2'd1, 1'b0, 2, 3};
        t_step[6] = '{8'd157, 2'd3, 1'b1, 2, 4};
        t_step[7] = '{8'd1,   2'd3, 1'b0, 2, 154};
        t_step[8] = '{8'd158, 2'd1, 1'b1, 1, 0};
`endif

        // Reset state and one complete pass.
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_plot", int'(vga_plot), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_step_done", int'(step_done), 0);
        check("reset_x", int'(vga_x), 0);
        check("reset_colour", int'(vga_colour), 0);
        start(8'd0, 7'd0, 2'd0, 1'b1);
        wait_plot("pass_first_plot");
        for (int i = 0; i < 25; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("pass[%0d]_plot", i), int'(vga_plot), int'(t_pass[i].plot));
            check($sformatf("pass[%0d]_step_done", i), int'(step_done), int'(t_pass[i].sd));
            if (t_pass[i].plot) begin
                check($sformatf("pass[%0d]_x", i), int'(vga_x), t_pass[i].x);
                check($sformatf("pass[%0d]_y", i), int'(vga_y), t_pass[i].y);
                check($sformatf("pass[%0d]_colour", i), int'(vga_colour), t_pass[i].c);
            end
        end

        // Step arithmetic, wrap / bounce at the edges.
        for (int v = 0; v < 9; v++) begin
            start(t_step[v].x0, 7'd0, t_step[v].sp, t_step[v].d);
            for (int s = 0; s < t_step[v].steps; s++) wait_step($sformatf("step[%0d]_done", v));
            wait_plot($sformatf("step[%0d]_draw", v));
            check($sformatf("step[%0d]_x", v), int'(vga_x), t_step[v].exp_x);
            check($sformatf("step[%0d]_y", v), int'(vga_y), 0);
        end

        // Clipping at the right edge keeps the sweep length.
        begin
            logic [8:0] exp_plot;
            exp_plot = 9'b0_1111_0101;
            start(8'd159, 7'd0, 2'd0, 1'b1);
            wait_plot("clip_first_plot");
            for (int i = 0; i < 9; i++) begin
                if (i > 0) @(negedge clk);
                check($sformatf("clip[%0d]_plot", i), int'(vga_plot), int'(exp_plot[i]));
                if (i == 1) check("clip_x", int'(vga_x), 160);
            end
        end

        // Dropping enable mid-DRAW completes the pass, then parks.
        begin
            int plots;
            int k;
            int sd;
            int bz;
            start(8'd30, 7'd20, 2'd1, 1'b1);
            wait_plot("drop_first_plot");
            check("drop_busy_running", int'(busy), 1);
            plots = 1;
            k = 0;
            do begin
                @(negedge clk);
                k++;
                if (k == 2) enable = 1'b0;
                if (vga_plot) plots++;
            end while (!step_done && k < 200);
            check("drop_step_done", int'(step_done), 1);
            check("drop_plot_count", plots, 16);
            check("drop_busy_idle", int'(busy), 0);
            plots = 0;
            sd = 0;
            bz = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (vga_plot) plots++;
                if (step_done) sd++;
                if (busy) bz++;
            end
            check("drop_idle_plots", plots, 0);
            check("drop_idle_step_done", sd, 0);
            check("drop_idle_busy", bz, 0);
        end

        // Reset during ERASE aborts and restores initial positions.
        start(8'd20, 7'd30, 2'd1, 1'b1);
        wait_step("rst_first_step");
        wait_plot("rst_second_draw");
        check("rst_stepped_x", int'(vga_x), 21);
        repeat (18) @(negedge clk);
        check("rst_erase_plot", int'(vga_plot), 1);
        check("rst_erase_colour", int'(vga_colour), 0);
        check("rst_erase_y", int'(vga_y), 31);
        check("rst_erase_busy", int'(busy), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_abort_plot", int'(vga_plot), 0);
        check("rst_abort_busy", int'(busy), 0);
        @(negedge clk);
        check("rst_hold_plot", int'(vga_plot), 0);
        reset_n = 1'b1;
        wait_plot("rst_restart_draw");
        check("rst_restart_x", int'(vga_x), 20);
        check("rst_restart_y", int'(vga_y), 30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
